// File: rtl/pingpong_bank_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pingpong_pkg
// Shared definitions for the N-bank ping-pong controller on the SCI receive
// path.
//   state_e    : controller states (idle/arming, running, swap strobe,
//                waiting for the read bank to drain)
//   sel_width  : width of a bank select for a given bank count (minimum 1)
//   next_bank  : bank index after sel, wrapping n-1 -> 0
//   prev_bank  : bank index before sel, wrapping 0 -> n-1
// ---------------------------------------------------------------------------
package pingpong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_SWAP      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned next_bank(input int unsigned sel, input int unsigned n);
    return (sel >= n - 1) ? 0 : sel + 1;
  endfunction

  function automatic int unsigned prev_bank(input int unsigned sel, input int unsigned n);
    return (sel == 0) ? n - 1 : sel - 1;
  endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// pingpong_bank_ctrl_if
// Bundles every controller signal except clk/rst.
//   Control in : record, new_instr, end_instr, comple, err_clr
//   Streams in : rx_valid/rx_data (live), err_valid/err_data (readback)
//   Banks out  : bank_valid[NBANK], bank_data[NBANK*DW] (bank k at k*DW)
//   Status out : wr_sel, rd_sel, swap_pulse, busy, overrun_err, swap_cnt
// master drives the inputs and observes the outputs; slave is the controller.
// ---------------------------------------------------------------------------
interface pingpong_bank_ctrl_if
  import pingpong_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NBANK = 2,
  parameter int CNTW  = 16
);

  localparam int SW = sel_width(NBANK);

  logic                record;
  logic                new_instr;
  logic                end_instr;
  logic                comple;
  logic                err_clr;
  logic                rx_valid;
  logic [DW-1:0]       rx_data;
  logic                err_valid;
  logic [DW-1:0]       err_data;
  logic [NBANK-1:0]    bank_valid;
  logic [NBANK*DW-1:0] bank_data;
  logic [SW-1:0]       wr_sel;
  logic [SW-1:0]       rd_sel;
  logic                swap_pulse;
  logic                busy;
  logic                overrun_err;
  logic [CNTW-1:0]     swap_cnt;

  modport master (
    output record, new_instr, end_instr, comple, err_clr,
    output rx_valid, rx_data, err_valid, err_data,
    input  bank_valid, bank_data, wr_sel, rd_sel,
    input  swap_pulse, busy, overrun_err, swap_cnt
  );

  modport slave (
    input  record, new_instr, end_instr, comple, err_clr,
    input  rx_valid, rx_data, err_valid, err_data,
    output bank_valid, bank_data, wr_sel, rd_sel,
    output swap_pulse, busy, overrun_err, swap_cnt
  );

endinterface

// File: rtl/pingpong_bank_ctrl_route_mux.sv
// ---------------------------------------------------------------------------
// pingpong_route_mux
// Purely combinational steering of the two input streams onto the banks.
//   wr_sel_i              : bank that receives the live rx stream
//   rd_sel_i              : bank that receives the error/readback stream
//   rx_valid_i/rx_data_i  : live stream
//   err_valid_i/err_data_i: error/readback stream
//   bank_valid_o          : per-bank strobe
//   bank_data_o           : per-bank data, bank k at [k*DW +: DW]
// Banks that are neither selected see valid 0 and data 0.
// ---------------------------------------------------------------------------
module pingpong_route_mux
  import pingpong_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NBANK = 2
) (
  input  logic [sel_width(NBANK)-1:0] wr_sel_i,
  input  logic [sel_width(NBANK)-1:0] rd_sel_i,
  input  logic                        rx_valid_i,
  input  logic [DW-1:0]               rx_data_i,
  input  logic                        err_valid_i,
  input  logic [DW-1:0]               err_data_i,
  output logic [NBANK-1:0]            bank_valid_o,
  output logic [NBANK*DW-1:0]         bank_data_o
);

  localparam int SW = sel_width(NBANK);

  // wr_sel and rd_sel are always distinct, so priority order never matters.
  always_comb begin
    bank_valid_o = '0;
    bank_data_o  = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (SW'(k) == wr_sel_i) begin
        bank_valid_o[k]          = rx_valid_i;
        bank_data_o[k*DW +: DW]  = rx_data_i;
      end else if (SW'(k) == rd_sel_i) begin
        bank_valid_o[k]          = err_valid_i;
        bank_data_o[k*DW +: DW]  = err_data_i;
      end
    end
  end

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_bank_ctrl
// N-bank ping-pong controller for the SCI receive path. The live rx stream
// goes to the write bank, the readback stream to the previously written
// bank; banks rotate on instruction boundaries once a session is armed.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : pingpong_bank_ctrl_if.slave (control pulses, streams, bank
//          outputs, wr_sel/rd_sel, swap_pulse, busy, overrun_err, swap_cnt)
// ---------------------------------------------------------------------------
module pingpong_bank_ctrl
  import pingpong_pkg::*;
#(
  parameter int DW          = 8,
  parameter int NBANK       = 2,
  parameter int ARM_COUNT   = 2,
  parameter int WAIT_COMPLE = 1,
  parameter int CNTW        = 16
) (
  input logic                 clk,
  input logic                 rst,
  pingpong_bank_ctrl_if.slave bus
);

  localparam int SW = sel_width(NBANK);
  localparam int AW = $clog2(ARM_COUNT + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   arm_cnt_q, arm_cnt_d;
  logic [SW-1:0]   wr_sel_q, wr_sel_d;
  logic [SW-1:0]   rd_sel;
  logic            pending_q, pending_d;
  logic            end_lat_q, end_lat_d;
  logic            overrun_q, overrun_d;
  logic [CNTW-1:0] swap_cnt_q, swap_cnt_d;
  logic            boundary;
  logic            do_swap;
  logic            ovr_set;

  assign boundary = bus.new_instr | bus.end_instr;
  assign rd_sel   = SW'(prev_bank(32'(wr_sel_q), NBANK));

  // State register and all sequential bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      arm_cnt_q  <= '0;
      wr_sel_q   <= '0;
      pending_q  <= 1'b0;
      end_lat_q  <= 1'b0;
      overrun_q  <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      wr_sel_q   <= wr_sel_d;
      pending_q  <= pending_d;
      end_lat_q  <= end_lat_d;
      overrun_q  <= overrun_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  // Next-state logic. A boundary seen while the read bank is still draining
  // is held as a single pending swap and flags an overrun; end_instr is
  // OR-ed into end_lat so the session still ends after the pending swap.
  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    pending_d  = pending_q;
    end_lat_d  = end_lat_q;
    do_swap    = 1'b0;
    ovr_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.record) begin
          if (arm_cnt_q == AW'(ARM_COUNT - 1)) begin
            arm_cnt_d = '0;
            state_d   = ST_RUN;
          end else begin
            arm_cnt_d = arm_cnt_q + AW'(1);
          end
        end
      end
      ST_RUN: begin
        if (boundary) begin
          do_swap   = 1'b1;
          end_lat_d = bus.end_instr;
          state_d   = ST_SWAP;
        end
      end
      ST_SWAP: begin
        if (WAIT_COMPLE != 0) begin
          state_d = ST_WAIT_DONE;
        end else if (end_lat_q) begin
          end_lat_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.comple && (pending_q || boundary)) begin
          do_swap   = 1'b1;
          end_lat_d = pending_q ? (end_lat_q | bus.end_instr) : bus.end_instr;
          pending_d = 1'b0;
          state_d   = ST_SWAP;
        end else if (boundary) begin
          pending_d = 1'b1;
          ovr_set   = 1'b1;
          end_lat_d = end_lat_q | bus.end_instr;
        end else if (bus.comple) begin
          if (end_lat_q) begin
            end_lat_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_sel_d   = do_swap ? SW'(next_bank(32'(wr_sel_q), NBANK)) : wr_sel_q;
    swap_cnt_d = do_swap ? swap_cnt_q + CNTW'(1) : swap_cnt_q;
    // A new overrun in the same cycle as err_clr keeps the flag set.
    overrun_d  = ovr_set ? 1'b1 : (bus.err_clr ? 1'b0 : overrun_q);
  end

  assign bus.wr_sel      = wr_sel_q;
  assign bus.rd_sel      = rd_sel;
  assign bus.swap_pulse  = (state_q == ST_SWAP);
  assign bus.busy        = (state_q == ST_SWAP) || (state_q == ST_WAIT_DONE);
  assign bus.overrun_err = overrun_q;
  assign bus.swap_cnt    = swap_cnt_q;

  pingpong_route_mux #(
    .DW    (DW),
    .NBANK (NBANK)
  ) u_route (
    .wr_sel_i    (wr_sel_q),
    .rd_sel_i    (rd_sel),
    .rx_valid_i  (bus.rx_valid),
    .rx_data_i   (bus.rx_data),
    .err_valid_i (bus.err_valid),
    .err_data_i  (bus.err_data),
    .bank_valid_o(bus.bank_valid),
    .bank_data_o (bus.bank_data)
  );

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_bank_ctrl
// Two controllers: dutA (3 banks, arm 2, waits for comple) exercised with
// directed scenarios and a randomized run against a behavioural model;
// dutB (4 banks, arm 1, no drain wait) exercised for routing and the
// direct return path from a swap.
// ---------------------------------------------------------------------------
module tb_pingpong_bank_ctrl;

  localparam int A_NB = 3;
  localparam int B_NB = 4;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  int   expWr;
  int   expCnt;

  // Behavioural model of dutA: session flag, record tally, swap strobe,
  // drain wait, one pending swap, end-of-session latch, overrun flag.
  bit   mSession, mStrobe, mDrain, mPend, mEnd, mOvr;
  int   mRec, mWr, mCnt;

  pingpong_bank_ctrl_if #(.DW(8), .NBANK(A_NB), .CNTW(16)) ifa ();
  pingpong_bank_ctrl_if #(.DW(8), .NBANK(B_NB), .CNTW(16)) ifb ();

  pingpong_bank_ctrl #(
    .DW(8), .NBANK(A_NB), .ARM_COUNT(2), .WAIT_COMPLE(1), .CNTW(16)
  ) dutA (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  pingpong_bank_ctrl #(
    .DW(8), .NBANK(B_NB), .ARM_COUNT(1), .WAIT_COMPLE(0), .CNTW(16)
  ) dutB (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mSession = 0; mStrobe = 0; mDrain = 0; mPend = 0; mEnd = 0; mOvr = 0;
    mRec = 0; mWr = 0; mCnt = 0;
  endtask

  task automatic model_swap();
    mWr  = (mWr + 1) % A_NB;
    mCnt = (mCnt + 1) % 65536;
  endtask

  // Applies the rules for one clock edge using dutA's current inputs.
  task automatic model_step();
    bit bnd;
    bit setOvr;
    if (rst) begin
      model_reset();
      return;
    end
    bnd    = ifa.new_instr | ifa.end_instr;
    setOvr = 0;
    if (mStrobe) begin
      mStrobe = 0;
      mDrain  = 1;
    end else if (mDrain) begin
      if (ifa.comple && (mPend || bnd)) begin
        mEnd    = mPend ? (mEnd | ifa.end_instr) : ifa.end_instr;
        mPend   = 0;
        model_swap();
        mDrain  = 0;
        mStrobe = 1;
      end else if (bnd) begin
        mPend  = 1;
        setOvr = 1;
        mEnd   = mEnd | ifa.end_instr;
      end else if (ifa.comple) begin
        mDrain = 0;
        if (mEnd) begin
          mSession = 0;
          mEnd     = 0;
        end
      end
    end else if (mSession) begin
      if (bnd) begin
        model_swap();
        mEnd    = ifa.end_instr;
        mStrobe = 1;
      end
    end else if (ifa.record) begin
      mRec++;
      if (mRec == 2) begin
        mRec     = 0;
        mSession = 1;
      end
    end
    if (setOvr) mOvr = 1;
    else if (ifa.err_clr) mOvr = 0;
  endtask

  // Advances one clock; inputs stay as set by the caller.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifa.record = 0; ifa.new_instr = 0; ifa.end_instr = 0; ifa.comple = 0; ifa.err_clr = 0;
    ifa.rx_valid = 0; ifa.rx_data = '0; ifa.err_valid = 0; ifa.err_data = '0;
    ifb.record = 0; ifb.new_instr = 0; ifb.end_instr = 0; ifb.comple = 0; ifb.err_clr = 0;
    ifb.rx_valid = 0; ifb.rx_data = '0; ifb.err_valid = 0; ifb.err_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    #1;
    nChecks++; if (ifa.wr_sel !== 2'd0) begin nFails++; $display("[TB] FAIL reset_wr_sel got %0d want 0", ifa.wr_sel); end
    nChecks++; if (ifa.rd_sel !== 2'd2) begin nFails++; $display("[TB] FAIL reset_rd_sel got %0d want 2", ifa.rd_sel); end
    nChecks++; if ({ifa.swap_pulse, ifa.busy, ifa.overrun_err} !== 3'b000) begin nFails++; $display("[TB] FAIL reset_flags got %b want 000", {ifa.swap_pulse, ifa.busy, ifa.overrun_err}); end
    nChecks++; if (ifa.swap_cnt !== 16'd0) begin nFails++; $display("[TB] FAIL reset_swap_cnt got %0d want 0", ifa.swap_cnt); end
    nChecks++; if (ifb.rd_sel !== 2'd3) begin nFails++; $display("[TB] FAIL reset_b_rd_sel got %0d want 3", ifb.rd_sel); end
    tick();
    rst = 1'b0;
    tick();
    expWr  = 0;
    expCnt = 0;
  endtask

  task automatic test_arming();
    ifa.record = 1; tick(); ifa.record = 0;
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    nChecks++; if (ifa.swap_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL arm1_no_swap got %b want 0", ifa.swap_pulse); end
    nChecks++; if (ifa.wr_sel !== 2'd0) begin nFails++; $display("[TB] FAIL arm1_wr_sel got %0d want 0", ifa.wr_sel); end
    nChecks++; if (ifa.swap_cnt !== 16'd0) begin nFails++; $display("[TB] FAIL arm1_swap_cnt got %0d want 0", ifa.swap_cnt); end
    ifa.record = 1; tick(); ifa.record = 0;
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    expWr = 1; expCnt = 1;
    nChecks++; if (ifa.swap_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL arm2_swap_pulse got %b want 1", ifa.swap_pulse); end
    nChecks++; if (ifa.wr_sel !== 2'd1 || ifa.rd_sel !== 2'd0) begin nFails++; $display("[TB] FAIL arm2_sel got wr=%0d rd=%0d want wr=1 rd=0", ifa.wr_sel, ifa.rd_sel); end
    nChecks++; if (ifa.swap_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL arm2_swap_cnt got %0d want 1", ifa.swap_cnt); end
    tick();
    nChecks++; if ({ifa.swap_pulse, ifa.busy} !== 2'b01) begin nFails++; $display("[TB] FAIL arm2_wait got pulse,busy=%b want 01", {ifa.swap_pulse, ifa.busy}); end
    ifa.comple = 1; tick(); ifa.comple = 0;
    nChecks++; if (ifa.busy !== 1'b0) begin nFails++; $display("[TB] FAIL arm2_drained busy got %b want 0", ifa.busy); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin
      ifa.new_instr = 1; tick(); ifa.new_instr = 0;
      expWr  = (expWr + 1) % A_NB;
      expCnt = expCnt + 1;
      nChecks++; if (ifa.wr_sel !== 2'(expWr) || ifa.swap_pulse !== 1'b1) begin nFails++; $display("[TB] FAIL wrap_%0d got wr=%0d pulse=%b want wr=%0d pulse=1", i, ifa.wr_sel, ifa.swap_pulse, expWr); end
      nChecks++; if (ifa.rd_sel !== 2'((expWr + A_NB - 1) % A_NB)) begin nFails++; $display("[TB] FAIL wrap_rd_%0d got %0d want %0d", i, ifa.rd_sel, (expWr + A_NB - 1) % A_NB); end
      tick();
      ifa.comple = 1; tick(); ifa.comple = 0;
    end
    nChecks++; if (ifa.swap_cnt !== 16'(expCnt)) begin nFails++; $display("[TB] FAIL wrap_swap_cnt got %0d want %0d", ifa.swap_cnt, expCnt); end
  endtask

  task automatic test_overrun();
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    expWr = (expWr + 1) % A_NB; expCnt++;
    tick();
    ifa.new_instr = 1; tick();
    nChecks++; if (ifa.overrun_err !== 1'b1) begin nFails++; $display("[TB] FAIL ovr_set got %b want 1", ifa.overrun_err); end
    nChecks++; if (ifa.swap_pulse !== 1'b0 || ifa.wr_sel !== 2'(expWr)) begin nFails++; $display("[TB] FAIL ovr_no_swap got pulse=%b wr=%0d want pulse=0 wr=%0d", ifa.swap_pulse, ifa.wr_sel, expWr); end
    ifa.err_clr = 1; tick(); ifa.err_clr = 0; ifa.new_instr = 0;
    nChecks++; if (ifa.overrun_err !== 1'b1 || ifa.swap_cnt !== 16'(expCnt)) begin nFails++; $display("[TB] FAIL ovr_set_wins got ovr=%b cnt=%0d want ovr=1 cnt=%0d", ifa.overrun_err, ifa.swap_cnt, expCnt); end
    ifa.comple = 1; tick(); ifa.comple = 0;
    expWr = (expWr + 1) % A_NB; expCnt++;
    nChecks++; if (ifa.swap_pulse !== 1'b1 || ifa.wr_sel !== 2'(expWr) || ifa.busy !== 1'b1) begin nFails++; $display("[TB] FAIL ovr_pending_swap got pulse=%b wr=%0d busy=%b want 1 %0d 1", ifa.swap_pulse, ifa.wr_sel, ifa.busy, expWr); end
    tick();
    nChecks++; if (ifa.busy !== 1'b1 || ifa.swap_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL ovr_busy got busy=%b pulse=%b want 1 0", ifa.busy, ifa.swap_pulse); end
    ifa.err_clr = 1; tick(); ifa.err_clr = 0;
    nChecks++; if (ifa.overrun_err !== 1'b0) begin nFails++; $display("[TB] FAIL ovr_clear got %b want 0", ifa.overrun_err); end
    ifa.comple = 1; tick(); ifa.comple = 0;
    tick();
    nChecks++; if (ifa.busy !== 1'b0 || ifa.swap_cnt !== 16'(expCnt)) begin nFails++; $display("[TB] FAIL ovr_pending_cleared got busy=%b cnt=%0d want 0 %0d", ifa.busy, ifa.swap_cnt, expCnt); end
  endtask

  task automatic test_end_session();
    ifa.end_instr = 1; tick(); ifa.end_instr = 0;
    expWr = (expWr + 1) % A_NB; expCnt++;
    tick();
    ifa.comple = 1; tick(); ifa.comple = 0;
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    nChecks++; if (ifa.swap_pulse !== 1'b0 || ifa.swap_cnt !== 16'(expCnt)) begin nFails++; $display("[TB] FAIL end_idle got pulse=%b cnt=%0d want 0 %0d", ifa.swap_pulse, ifa.swap_cnt, expCnt); end
    ifa.record = 1; tick(); ifa.record = 0;
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    nChecks++; if (ifa.swap_pulse !== 1'b0 || ifa.wr_sel !== 2'(expWr)) begin nFails++; $display("[TB] FAIL end_one_record got pulse=%b wr=%0d want 0 %0d", ifa.swap_pulse, ifa.wr_sel, expWr); end
    ifa.record = 1; tick(); ifa.record = 0;
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    expWr = (expWr + 1) % A_NB; expCnt++;
    nChecks++; if (ifa.swap_pulse !== 1'b1 || ifa.wr_sel !== 2'(expWr) || ifa.swap_cnt !== 16'(expCnt)) begin nFails++; $display("[TB] FAIL end_rearmed got pulse=%b wr=%0d cnt=%0d want 1 %0d %0d", ifa.swap_pulse, ifa.wr_sel, ifa.swap_cnt, expWr, expCnt); end
    tick();
    ifa.comple = 1; tick(); ifa.comple = 0;
  endtask

  task automatic test_routing_b();
    ifb.record = 1; tick(); ifb.record = 0;
    ifb.new_instr = 1; tick(); ifb.new_instr = 0;
    nChecks++; if (ifb.swap_pulse !== 1'b1 || ifb.wr_sel !== 2'd1) begin nFails++; $display("[TB] FAIL b_swap1 got pulse=%b wr=%0d want 1 1", ifb.swap_pulse, ifb.wr_sel); end
    tick();
    nChecks++; if (ifb.busy !== 1'b0 || ifb.swap_pulse !== 1'b0) begin nFails++; $display("[TB] FAIL b_no_wait got busy=%b pulse=%b want 0 0", ifb.busy, ifb.swap_pulse); end
    ifb.new_instr = 1; tick(); ifb.new_instr = 0;
    tick();
    ifb.rx_valid = 1; ifb.rx_data = 8'hA5; ifb.err_valid = 1; ifb.err_data = 8'h3C;
    #1;
    nChecks++; if (ifb.wr_sel !== 2'd2 || ifb.rd_sel !== 2'd1) begin nFails++; $display("[TB] FAIL b_sel got wr=%0d rd=%0d want 2 1", ifb.wr_sel, ifb.rd_sel); end
    nChecks++; if (ifb.bank_valid !== 4'b0110) begin nFails++; $display("[TB] FAIL b_route_valid got %b want 0110", ifb.bank_valid); end
    nChecks++; if (ifb.bank_data !== 32'h00A53C00) begin nFails++; $display("[TB] FAIL b_route_data got %h want 00a53c00", ifb.bank_data); end
    ifb.rx_valid = 0; ifb.err_valid = 0;
    ifb.end_instr = 1; ifb.new_instr = 1; tick(); ifb.end_instr = 0; ifb.new_instr = 0;
    tick();
    ifb.new_instr = 1; tick(); ifb.new_instr = 0;
    nChecks++; if (ifb.swap_pulse !== 1'b0 || ifb.wr_sel !== 2'd3 || ifb.swap_cnt !== 16'd3) begin nFails++; $display("[TB] FAIL b_end_idle got pulse=%b wr=%0d cnt=%0d want 0 3 3", ifb.swap_pulse, ifb.wr_sel, ifb.swap_cnt); end
  endtask

  task automatic test_async_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    ifa.record = 1; tick(); tick(); ifa.record = 0;
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    tick();
    ifa.new_instr = 1; tick(); ifa.new_instr = 0;
    nChecks++; if (ifa.wr_sel !== 2'd1 || ifa.overrun_err !== 1'b1 || ifa.busy !== 1'b1) begin nFails++; $display("[TB] FAIL pre_reset got wr=%0d ovr=%b busy=%b want 1 1 1", ifa.wr_sel, ifa.overrun_err, ifa.busy); end
    #2;
    rst = 1'b1;
    #1;
    nChecks++; if (ifa.wr_sel !== 2'd0 || ifa.rd_sel !== 2'd2) begin nFails++; $display("[TB] FAIL async_sel got wr=%0d rd=%0d want 0 2", ifa.wr_sel, ifa.rd_sel); end
    nChecks++; if ({ifa.overrun_err, ifa.busy, ifa.swap_pulse} !== 3'b000 || ifa.swap_cnt !== 16'd0) begin nFails++; $display("[TB] FAIL async_flags got flags=%b cnt=%0d want 000 0", {ifa.overrun_err, ifa.busy, ifa.swap_pulse}, ifa.swap_cnt); end
    nChecks++; if (ifb.wr_sel !== 2'd0 || ifb.swap_cnt !== 16'd0) begin nFails++; $display("[TB] FAIL async_b got wr=%0d cnt=%0d want 0 0", ifb.wr_sel, ifb.swap_cnt); end
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [2:0]  ev;
    logic [23:0] ed;
    int          rdExp;
    for (int c = 0; c < 600; c++) begin
      ifa.record    = ($urandom_range(0, 3) == 0);
      ifa.new_instr = ($urandom_range(0, 5) == 0);
      ifa.end_instr = ($urandom_range(0, 11) == 0);
      ifa.comple    = ($urandom_range(0, 3) == 0);
      ifa.err_clr   = ($urandom_range(0, 9) == 0);
      ifa.rx_valid  = $urandom_range(0, 1) == 1;
      ifa.err_valid = $urandom_range(0, 1) == 1;
      ifa.rx_data   = 8'($urandom);
      ifa.err_data  = 8'($urandom);
      #1;
      rdExp = (mWr + A_NB - 1) % A_NB;
      ev = '0;
      ed = '0;
      for (int k = 0; k < A_NB; k++) begin
        if (k == mWr) begin ev[k] = ifa.rx_valid; ed[k*8 +: 8] = ifa.rx_data; end
        else if (k == rdExp) begin ev[k] = ifa.err_valid; ed[k*8 +: 8] = ifa.err_data; end
      end
      nChecks++; if (ifa.wr_sel !== 2'(mWr) || ifa.rd_sel !== 2'(rdExp)) begin nFails++; $display("[TB] FAIL rnd_sel cyc %0d got wr=%0d rd=%0d want %0d %0d", c, ifa.wr_sel, ifa.rd_sel, mWr, rdExp); end
      nChecks++; if (ifa.swap_pulse !== mStrobe || ifa.busy !== (mStrobe | mDrain)) begin nFails++; $display("[TB] FAIL rnd_strobe cyc %0d got pulse=%b busy=%b want %b %b", c, ifa.swap_pulse, ifa.busy, mStrobe, mStrobe | mDrain); end
      nChecks++; if (ifa.overrun_err !== mOvr) begin nFails++; $display("[TB] FAIL rnd_overrun cyc %0d got %b want %b", c, ifa.overrun_err, mOvr); end
      nChecks++; if (ifa.swap_cnt !== 16'(mCnt)) begin nFails++; $display("[TB] FAIL rnd_swap_cnt cyc %0d got %0d want %0d", c, ifa.swap_cnt, mCnt); end
      nChecks++; if (ifa.bank_valid !== ev || ifa.bank_data !== ed) begin nFails++; $display("[TB] FAIL rnd_route cyc %0d got v=%b d=%h want v=%b d=%h", c, ifa.bank_valid, ifa.bank_data, ev, ed); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst     = 1'b1;
    clear_inputs();
    $display("[TB] starting");
    test_reset();
    test_arming();
    test_wrap();
    test_overrun();
    test_end_session();
    test_routing_b();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
